// File: rtl/uart_frame_check.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_check
// Purpose  : UART receive framing FSM: start/data/parity/stop checking.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_req,
    input  logic                  sample_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  frame_busy,
    output logic                  start_glitch,
    output logic                  par_err,
    output logic                  stop_err
);

    localparam int              CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;
    logic [DATA_WIDTH-1:0]   p_data_nxt;
    logic                    stop_cnt, stop_cnt_nxt;
    logic                    par_en_q, par_en_nxt;
    logic                    par_typ_q, par_typ_nxt;
    logic                    par_fail, par_fail_nxt;
    logic                    stop_fail, stop_fail_nxt;
    logic                    dv_nxt, glitch_nxt, par_err_nxt, stop_err_nxt;
    logic                    stop_fail_now;
    logic                    par_expected;

    // Flags include the stop sample being consumed this cycle.
    assign stop_fail_now = stop_fail | ~sampled_bit;
    assign par_expected  = (^shift_reg) ^ par_typ_q;
    assign frame_busy    = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            stop_cnt     <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail     <= 1'b0;
            stop_fail    <= 1'b0;
            p_data       <= '0;
            data_valid   <= 1'b0;
            start_glitch <= 1'b0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift_reg    <= shift_nxt;
            stop_cnt     <= stop_cnt_nxt;
            par_en_q     <= par_en_nxt;
            par_typ_q    <= par_typ_nxt;
            par_fail     <= par_fail_nxt;
            stop_fail    <= stop_fail_nxt;
            p_data       <= p_data_nxt;
            data_valid   <= dv_nxt;
            start_glitch <= glitch_nxt;
            par_err      <= par_err_nxt;
            stop_err     <= stop_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        stop_cnt_nxt  = stop_cnt;
        par_en_nxt    = par_en_q;
        par_typ_nxt   = par_typ_q;
        par_fail_nxt  = par_fail;
        stop_fail_nxt = stop_fail;
        p_data_nxt    = p_data;
        dv_nxt        = 1'b0;
        glitch_nxt    = 1'b0;
        par_err_nxt   = 1'b0;
        stop_err_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                // A coincident sample_valid is deliberately not consumed here.
                if (start_req) begin
                    state_nxt   = S_START;
                    par_en_nxt  = par_en;
                    par_typ_nxt = par_typ;
                end
            end
            S_START: begin
                if (sample_valid) begin
                    if (sampled_bit) begin
                        state_nxt  = S_IDLE;
                        glitch_nxt = 1'b1;
                    end else begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            S_DATA: begin
                if (sample_valid) begin
                    shift_nxt = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_cnt == CNT_LAST) begin
                        state_nxt    = par_en_q ? S_PARITY : S_STOP;
                        stop_cnt_nxt = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (sample_valid) begin
                    if (sampled_bit != par_expected) begin
                        par_fail_nxt = 1'b1;
                    end
                    state_nxt    = S_STOP;
                    stop_cnt_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (sample_valid) begin
                    if (stop_cnt == STOP_LAST) begin
                        par_err_nxt  = par_fail;
                        stop_err_nxt = stop_fail_now;
                        if (!(par_fail || stop_fail_now)) begin
                            dv_nxt     = 1'b1;
                            p_data_nxt = shift_reg;
                        end
                        state_nxt     = S_IDLE;
                        bit_cnt_nxt   = '0;
                        stop_cnt_nxt  = 1'b0;
                        par_fail_nxt  = 1'b0;
                        stop_fail_nxt = 1'b0;
                    end else begin
                        stop_fail_nxt = stop_fail_now;
                        stop_cnt_nxt  = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_check
// Purpose  : Frame-level reference model bench for two uart_frame_check builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_check;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] sreq, sv, sbit, pe, pt;
    wire  [7:0] pd_a;
    wire  [4:0] pd_b;
    wire  [1:0] dv, busy, sg, perr, serr;

    always #5 CLK = ~CLK;

    // Instance 0: 8 data bits, 1 stop bit. Instance 1: 5 data bits, 2 stop bits.
    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST(RST), .start_req(sreq[0]), .sample_valid(sv[0]),
        .sampled_bit(sbit[0]), .par_en(pe[0]), .par_typ(pt[0]),
        .p_data(pd_a), .data_valid(dv[0]), .frame_busy(busy[0]),
        .start_glitch(sg[0]), .par_err(perr[0]), .stop_err(serr[0])
    );

    uart_frame_check #(.DATA_WIDTH(5), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(RST), .start_req(sreq[1]), .sample_valid(sv[1]),
        .sampled_bit(sbit[1]), .par_en(pe[1]), .par_typ(pt[1]),
        .p_data(pd_b), .data_valid(dv[1]), .frame_busy(busy[1]),
        .start_glitch(sg[1]), .par_err(perr[1]), .stop_err(serr[1])
    );

    logic [1:0] e_dv, e_busy, e_sg, e_perr, e_serr;
    logic [8:0] e_pd [2];
    int         nvec = 0;
    int         nfail = 0;
    bit         checking = 1'b0;
    bit         force_sreq = 1'b0;

    task automatic chk(input string name, input int k, input logic [8:0] act, input logic [8:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] act_pd(input int k);
        return (k == 0) ? {1'b0, pd_a} : {4'b0, pd_b};
    endfunction

    always @(negedge CLK) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                chk("data_valid",   k, {8'b0, dv[k]},   {8'b0, e_dv[k]});
                chk("frame_busy",   k, {8'b0, busy[k]}, {8'b0, e_busy[k]});
                chk("start_glitch", k, {8'b0, sg[k]},   {8'b0, e_sg[k]});
                chk("par_err",      k, {8'b0, perr[k]}, {8'b0, e_perr[k]});
                chk("stop_err",     k, {8'b0, serr[k]}, {8'b0, e_serr[k]});
                chk("p_data",       k, act_pd(k),       e_pd[k]);
            end
        end
    end

    // Advance one clock; pulses expected only in the cycle the caller sets them.
    task automatic tick();
        @(posedge CLK);
        #1;
        e_dv   = '0;
        e_sg   = '0;
        e_perr = '0;
        e_serr = '0;
    endtask

    task automatic reset_exp();
        e_busy = '0;
        e_pd[0] = '0;
        e_pd[1] = '0;
    endtask

    // Deliver one mid-bit sample after 0..2 idle cycles carrying noise.
    task automatic sample(input int k, input logic b);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            sreq[k] = force_sreq | 1'($urandom);
            sv[k]   = 1'b0;
            sbit[k] = 1'($urandom);
            pe[k]   = 1'($urandom);
            pt[k]   = 1'($urandom);
            tick();
        end
        sreq[k] = force_sreq | 1'($urandom);
        sv[k]   = 1'b1;
        sbit[k] = b;
        tick();
        sv[k]   = 1'b0;
        sreq[k] = 1'b0;
    endtask

    task automatic frame(input int k, input logic pen, input logic ptyp, input logic [8:0] data_in,
                         input logic start_bit, input logic par_flip, input logic [1:0] stops,
                         input int abort_at);
        int         w;
        int         nsb;
        logic [8:0] data;
        logic       pf;
        logic       sf;
        w    = (k == 0) ? 8 : 5;
        nsb  = (k == 0) ? 1 : 2;
        data = data_in & ((9'd1 << w) - 9'd1);
        sreq[k] = 1'b1;
        pe[k]   = pen;
        pt[k]   = ptyp;
        sv[k]   = 1'($urandom);
        sbit[k] = 1'($urandom);
        tick();
        e_busy[k] = 1'b1;
        sreq[k] = 1'b0;
        sv[k]   = 1'b0;
        sample(k, start_bit);
        if (start_bit) begin
            e_sg[k]   = 1'b1;
            e_busy[k] = 1'b0;
            return;
        end
        for (int i = 0; i < w; i++) begin
            if (i == abort_at) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                reset_exp();
                return;
            end
            sample(k, data[i]);
        end
        pf = 1'b0;
        if (pen) begin
            sample(k, (^data) ^ ptyp ^ par_flip);
            pf = par_flip;
        end
        sf = 1'b0;
        for (int s = 0; s < nsb; s++) begin
            sample(k, stops[s]);
            if (!stops[s]) sf = 1'b1;
        end
        e_busy[k] = 1'b0;
        e_perr[k] = pf;
        e_serr[k] = sf;
        if (!pf && !sf) begin
            e_dv[k] = 1'b1;
            e_pd[k] = data;
        end
    endtask

    initial begin
        RST = 1'b1;
        sreq = '0; sv = '0; sbit = '0; pe = '0; pt = '0;
        e_dv = '0; e_busy = '0; e_sg = '0; e_perr = '0; e_serr = '0;
        e_pd[0] = '0; e_pd[1] = '0;
        tick();
        checking = 1'b1;
        tick();
        RST = 1'b0;
        chk("lit_reset_pd", 0, {1'b0, pd_a}, 9'h000);

        frame(0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 2'b11, -1);
        chk("lit_dv_a5", 0, {8'b0, dv[0]}, 9'h001);
        chk("lit_pd_a5", 0, {1'b0, pd_a}, 9'h0A5);

        frame(0, 1'b1, 1'b0, 9'h003, 1'b0, 1'b1, 2'b11, -1);
        chk("lit_perr", 0, {8'b0, perr[0]}, 9'h001);
        chk("lit_pd_hold", 0, {1'b0, pd_a}, 9'h0A5);

        frame(0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 2'b11, -1);
        chk("lit_glitch", 0, {8'b0, sg[0]}, 9'h001);
        frame(0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0, 2'b11, -1);
        chk("lit_pd_5a", 0, {1'b0, pd_a}, 9'h05A);

        frame(1, 1'b1, 1'b1, 9'h016, 1'b0, 1'b0, 2'b01, -1);
        chk("lit_serr", 1, {8'b0, serr[1]}, 9'h001);
        frame(1, 1'b1, 1'b0, 9'h016, 1'b0, 1'b1, 2'b00, -1);
        chk("lit_both_err", 1, {7'b0, perr[1], serr[1]}, 9'h003);

        frame(0, 1'b0, 1'b0, 9'h0C3, 1'b0, 1'b0, 2'b11, 4);
        chk("lit_abort_pd", 0, {1'b0, pd_a}, 9'h000);
        frame(0, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0, 2'b11, -1);
        chk("lit_pd_ff", 0, {1'b0, pd_a}, 9'h0FF);

        force_sreq = 1'b1;
        frame(1, 1'b1, 1'b1, 9'h016, 1'b0, 1'b0, 2'b11, -1);
        force_sreq = 1'b0;
        chk("lit_pd_10110", 1, {4'b0, pd_b}, 9'h016);

        for (int n = 0; n < 300; n++) begin
            int   k;
            int   w;
            int   ab;
            logic [1:0] stops;
            k     = $urandom_range(0, 1);
            w     = (k == 0) ? 8 : 5;
            stops = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            ab    = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, w - 1)) : -1;
            frame(k, 1'($urandom), 1'($urandom), 9'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), stops, ab);
            if ($urandom_range(0, 3) == 0) tick();
        end

        tick();
        tick();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
